// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one data-memory port between the CPU MEM stage (m0) and a debug/DMA loader (m1).
// Each transaction takes three cycles: an IDLE cycle to arbitrate, ISSUE to access memory, and DONE to ack.
`default_nettype none

`ifndef DM_OP_BIT
`define DM_OP_BIT 2:0
`define DM_OP_WD  3'd0
`define DM_OP_UH  3'd1
`define DM_OP_UB  3'd2
`define DM_OP_SH  3'd3
`define DM_OP_SB  3'd4
`endif

module dm_port_arbiter #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int AW         = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [`DM_OP_BIT]    m0_op,
    input  logic [AW-1:0]        m0_addr,
    input  logic [31:0]          m0_wdata,
    output logic                 m0_ack,
    output logic                 m0_err,
    output logic [31:0]          m0_rdata,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [`DM_OP_BIT]    m1_op,
    input  logic [AW-1:0]        m1_addr,
    input  logic [31:0]          m1_wdata,
    output logic                 m1_ack,
    output logic                 m1_err,
    output logic [31:0]          m1_rdata,
    output logic                 dm_en,
    output logic                 dm_w_en,
    output logic [`DM_OP_BIT]    dm_op,
    output logic [AW-1:0]        dm_addr,
    output logic [31:0]          dm_wdata,
    input  logic [31:0]          dm_rdata,
    output logic                 busy,
    output logic                 grant_id
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_grant;
    logic                r_we;
    logic                r_misal;

    logic                w_pick;
    logic                w_sel_we;
    logic [`DM_OP_BIT]   w_sel_op;
    logic [AW-1:0]       w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic                w_sel_misal;

    function automatic logic misaligned(input logic [`DM_OP_BIT] op, input logic [1:0] a);
        logic m;
        m = 1'b0;
        case (op)
            `DM_OP_WD:           m = (a != 2'b00);
            `DM_OP_UH, `DM_OP_SH: m = a[0];
            default:             m = 1'b0;
        endcase
        return m;
    endfunction

    // On a tie the requester that did not win last time gets the port, unless m0 has fixed priority.
    always_comb begin
        w_pick = 1'b0;
        if (m0_req && m1_req)
            w_pick = FIXED_PRIO ? 1'b0 : ~r_last_grant;
        else if (m1_req)
            w_pick = 1'b1;
        w_sel_we    = w_pick ? m1_we    : m0_we;
        w_sel_op    = w_pick ? m1_op    : m0_op;
        w_sel_addr  = w_pick ? m1_addr  : m0_addr;
        w_sel_wdata = w_pick ? m1_wdata : m0_wdata;
        w_sel_misal = misaligned(w_sel_op, w_sel_addr[1:0]);
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_misal      <= 1'b0;
            grant_id     <= 1'b0;
            m0_ack       <= 1'b0;
            m0_err       <= 1'b0;
            m0_rdata     <= 32'h0;
            m1_ack       <= 1'b0;
            m1_err       <= 1'b0;
            m1_rdata     <= 32'h0;
            dm_en        <= 1'b0;
            dm_w_en      <= 1'b0;
            dm_op        <= '0;
            dm_addr      <= '0;
            dm_wdata     <= 32'h0;
        end else begin
            m0_ack  <= 1'b0;
            m0_err  <= 1'b0;
            m1_ack  <= 1'b0;
            m1_err  <= 1'b0;
            dm_en   <= 1'b0;
            dm_w_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        grant_id     <= w_pick;
                        r_last_grant <= w_pick;
                        r_we         <= w_sel_we;
                        r_misal      <= w_sel_misal;
                        dm_op        <= w_sel_op;
                        dm_addr      <= w_sel_addr;
                        dm_wdata     <= w_sel_wdata;
                        // Memory strobes are registered so they are valid for exactly the ISSUE cycle.
                        dm_en        <= ~w_sel_misal;
                        dm_w_en      <= w_sel_we & ~w_sel_misal;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!r_misal && !r_we) begin
                        if (grant_id) m1_rdata <= dm_rdata;
                        else          m0_rdata <= dm_rdata;
                    end
                    if (grant_id) begin
                        m1_ack <= 1'b1;
                        m1_err <= r_misal;
                    end else begin
                        m0_ack <= 1'b1;
                        m0_err <= r_misal;
                    end
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: scoreboard bench for dm_port_arbiter with a byte-addressed behavioural data memory.
`default_nettype none

`ifndef DM_OP_BIT
`define DM_OP_BIT 2:0
`define DM_OP_WD  3'd0
`define DM_OP_UH  3'd1
`define DM_OP_UB  3'd2
`define DM_OP_SH  3'd3
`define DM_OP_SB  3'd4
`endif

module tb_dm_port_arbiter;

    localparam logic [2:0] OP_BAD = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [2:0]  m0_op = 3'd0;
    logic [11:0] m0_addr = 12'h0;
    logic [31:0] m0_wdata = 32'h0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [2:0]  m1_op = 3'd0;
    logic [11:0] m1_addr = 12'h0;
    logic [31:0] m1_wdata = 32'h0;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        dm_en, dm_w_en, busy, grant_id;
    logic [2:0]  dm_op;
    logic [11:0] dm_addr;
    logic [31:0] dm_wdata, dm_rdata;

    logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_dm_en, fp_dm_w_en, fp_busy, fp_grant_id;
    logic [2:0]  fp_dm_op;
    logic [11:0] fp_dm_addr;
    logic [31:0] fp_dm_wdata;

    always #5 clk = ~clk;

    dm_port_arbiter #(.FIXED_PRIO(1'b0), .AW(12)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_op(m0_op), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_op(m1_op), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .dm_en(dm_en), .dm_w_en(dm_w_en), .dm_op(dm_op), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .busy(busy), .grant_id(grant_id)
    );

    // Fixed-priority instance sees the same requests; only its ack pattern is checked.
    dm_port_arbiter #(.FIXED_PRIO(1'b1), .AW(12)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_op(m0_op), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(fp_m0_ack), .m0_err(fp_m0_err), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_op(m1_op), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(fp_m1_ack), .m1_err(fp_m1_err), .m1_rdata(fp_m1_rdata),
        .dm_en(fp_dm_en), .dm_w_en(fp_dm_w_en), .dm_op(fp_dm_op), .dm_addr(fp_dm_addr),
        .dm_wdata(fp_dm_wdata), .dm_rdata(32'h0), .busy(fp_busy), .grant_id(fp_grant_id)
    );

    // Behavioural memory: little-endian bytes, combinational read, write on the clock edge.
    logic [7:0]  mem [0:4095];
    logic [31:0] mem_word;
    always_comb begin
        mem_word = {mem[dm_addr + 12'd3], mem[dm_addr + 12'd2], mem[dm_addr + 12'd1], mem[dm_addr]};
        case (dm_op)
            `DM_OP_WD: dm_rdata = mem_word;
            `DM_OP_UH: dm_rdata = {16'h0, mem_word[15:0]};
            `DM_OP_SH: dm_rdata = {{16{mem_word[15]}}, mem_word[15:0]};
            `DM_OP_UB: dm_rdata = {24'h0, mem_word[7:0]};
            `DM_OP_SB: dm_rdata = {{24{mem_word[7]}}, mem_word[7:0]};
            default:   dm_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (dm_en && dm_w_en) begin
            case (dm_op)
                `DM_OP_WD: begin
                    mem[dm_addr]         <= dm_wdata[7:0];
                    mem[dm_addr + 12'd1] <= dm_wdata[15:8];
                    mem[dm_addr + 12'd2] <= dm_wdata[23:16];
                    mem[dm_addr + 12'd3] <= dm_wdata[31:24];
                end
                `DM_OP_UH, `DM_OP_SH: begin
                    mem[dm_addr]         <= dm_wdata[7:0];
                    mem[dm_addr + 12'd1] <= dm_wdata[15:8];
                end
                `DM_OP_UB, `DM_OP_SB: mem[dm_addr] <= dm_wdata[7:0];
                default: ;
            endcase
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        id;
        logic        err;
        logic [31:0] rdata;
        logic        chk_rd;
    } exp_t;
    exp_t sb[$];

    int en_cnt = 0, wen_cnt = 0, fp0_cnt = 0, fp1_cnt = 0;

    always @(negedge clk) begin
        if (dm_en)     en_cnt++;
        if (dm_w_en)   wen_cnt++;
        if (fp_m0_ack) fp0_cnt++;
        if (fp_m1_ack) fp1_cnt++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n && (m0_ack || m1_ack)) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", {30'h0, m1_ack, m0_ack}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("ack_owner", {30'h0, m1_ack, m0_ack}, e.id ? 32'h2 : 32'h1);
                chk("err", {31'h0, e.id ? m1_err : m0_err}, {31'h0, e.err});
                if (e.chk_rd) chk("rdata", e.id ? m1_rdata : m0_rdata, e.rdata);
            end
        end
    end

    task automatic set_cmd(input logic id, input logic we, input logic [2:0] op,
                           input logic [11:0] addr, input logic [31:0] wd);
        if (id) begin
            m1_req = 1'b1; m1_we = we; m1_op = op; m1_addr = addr; m1_wdata = wd;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_op = op; m0_addr = addr; m0_wdata = wd;
        end
    endtask

    task automatic txn(input logic id, input logic we, input logic [2:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic eerr, input logic [31:0] erd, input logic crd);
        int   cyc, en0, wen0;
        logic got;
        @(posedge clk); #1;
        sb.push_back('{id, eerr, erd, crd});
        en0 = en_cnt; wen0 = wen_cnt;
        set_cmd(id, we, op, addr, wd);
        cyc = 1; got = 1'b0;
        while (!got && cyc <= 8) begin
            @(negedge clk);
            if ((id ? m1_ack : m0_ack) === 1'b1) got = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (id) m1_req = 1'b0; else m0_req = 1'b0;
        chk("ack_seen", {31'h0, got}, 32'h1);
        chk("latency", 32'(cyc), 32'd3);
        chk("dm_en_cycles", 32'(en_cnt - en0), eerr ? 32'd0 : 32'd1);
        chk("dm_wen_cycles", 32'(wen_cnt - wen0), (we && !eerr) ? 32'd1 : 32'd0);
    endtask

    // Both requesters load continuously; grants must alternate starting at 'first'.
    task automatic tie(input int n, input logic first,
                       input logic [2:0] op0, input logic [11:0] a0, input logic [31:0] e0,
                       input logic [2:0] op1, input logic [11:0] a1, input logic [31:0] e1);
        int   k, cyc, f0, f1;
        logic g;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            g = first ^ i[0];
            sb.push_back('{g, 1'b0, g ? e1 : e0, 1'b1});
        end
        f0 = fp0_cnt; f1 = fp1_cnt;
        set_cmd(1'b0, 1'b0, op0, a0, 32'h0);
        set_cmd(1'b1, 1'b0, op1, a1, 32'h0);
        k = 0; cyc = 0;
        while (k < n && cyc < 4 * n + 4) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                g = first ^ k[0];
                chk("tie_grant_id", {31'h0, grant_id}, {31'h0, g});
                k++;
            end
            if (k < n) begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk); #1;
        chk("tie_count", 32'(k), 32'(n));
        chk("fixed_prio_m0_acks", 32'(fp0_cnt - f0), 32'(n));
        chk("fixed_prio_m1_acks", 32'(fp1_cnt - f1), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {26'h0, m0_ack, m1_ack, m0_err, m1_err, dm_en, dm_w_en}, 32'h0);
        chk("rst_busy_gid", {30'h0, busy, grant_id}, 32'h0);
        chk("rst_rdata", m0_rdata | m1_rdata | dm_wdata, 32'h0);
        @(negedge clk) rst_n = 1'b0;

        // Word store/load round trip, then a misaligned store that must not touch memory.
        txn(1'b0, 1'b1, `DM_OP_WD, 12'h010, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        txn(1'b0, 1'b0, `DM_OP_WD, 12'h010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
        txn(1'b0, 1'b1, `DM_OP_WD, 12'h012, 32'h55555555, 1'b1, 32'hDEADBEEF, 1'b1);
        txn(1'b0, 1'b0, `DM_OP_WD, 12'h010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);

        // Byte/half accesses from m1, sign and zero extension, misaligned half, unknown op.
        txn(1'b1, 1'b1, `DM_OP_UB, 12'h013, 32'h00000080, 1'b0, 32'h0, 1'b0);
        txn(1'b1, 1'b0, `DM_OP_SB, 12'h013, 32'h0, 1'b0, 32'hFFFFFF80, 1'b1);
        txn(1'b1, 1'b0, `DM_OP_UB, 12'h013, 32'h0, 1'b0, 32'h00000080, 1'b1);
        txn(1'b1, 1'b0, `DM_OP_SH, 12'h012, 32'h0, 1'b0, 32'hFFFF80AD, 1'b1);
        txn(1'b1, 1'b0, `DM_OP_UH, 12'h011, 32'h0, 1'b1, 32'hFFFF80AD, 1'b1);
        txn(1'b1, 1'b0, OP_BAD,    12'h010, 32'h0, 1'b0, 32'h00000000, 1'b1);
        chk("m0_rdata_hold", m0_rdata, 32'hDEADBEEF);

        // Continuous contention; last grant was m1 so m0 leads.
        tie(4, 1'b0, `DM_OP_WD, 12'h010, 32'h80ADBEEF, `DM_OP_UB, 12'h010, 32'h000000EF);

        // Reset in the middle of an m1 store must abort it cleanly.
        txn(1'b0, 1'b1, `DM_OP_WD, 12'h020, 32'h11223344, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        set_cmd(1'b1, 1'b1, `DM_OP_WD, 12'h020, 32'hCAFEF00D);
        @(posedge clk); #2;
        chk("t5_issue_wen", {31'h0, dm_w_en}, 32'h1);
        rst_n = 1'b1;
        #1;
        chk("t5_rst_strobes", {29'h0, dm_en, dm_w_en, busy}, 32'h0);
        m1_req = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_ack", {30'h0, m0_ack, m1_ack}, 32'h0);
        end
        tie(2, 1'b0, `DM_OP_WD, 12'h020, 32'h11223344, `DM_OP_UB, 12'h020, 32'h00000044);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
